// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the pwm_capture input-capture block.
package pwm_capture_pkg;

  typedef enum logic {IDLE, MEASURE} meas_state_t;
  typedef enum logic {W_IDLE, W_SEND} wr_state_t;

  localparam int unsigned CAP_BYTES      = 5;
  localparam int unsigned STATUS_OVR_BIT = 0;
  localparam int unsigned STATUS_SAT_BIT = 1;

  // Byte selected for register-file offset idx of a result record.
  function automatic logic [7:0] cap_byte(input logic [15:0] high,
                                          input logic [15:0] period,
                                          input logic [7:0]  status,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = high[7:0];
      3'd1:    b = high[15:8];
      3'd2:    b = period[7:0];
      3'd3:    b = period[15:8];
      default: b = status;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pwm_capture_writer.sv
// Capture buffer, byte sequencer and register-file write handshake.
module pwm_capture_writer
  import pwm_capture_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h0C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cap_valid,
  input  logic [15:0] cap_high,
  input  logic [15:0] cap_period,
  input  logic        sat_evt,
  output logic        reg_wr_valid,
  output logic [7:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  input  logic        reg_wr_ready,
  output logic        cap_busy
);

  wr_state_t   state_q, state_d;
  logic [2:0]  idx_q;
  logic [15:0] high_q, period_q;
  logic [7:0]  addr_q, data_q;
  logic [7:0]  status_now;
  logic        ovr_q, sat_q;
  logic        accept, last, ovr_evt, clr_ovr, clr_sat;

  assign accept  = (state_q == W_SEND) && reg_wr_ready;
  assign last    = (idx_q == 3'(CAP_BYTES - 1));
  assign ovr_evt = cap_valid && (state_q != W_IDLE);

  // Only the flag bits actually carried by the accepted status byte are
  // cleared, so an event arriving after the byte was loaded is not lost.
  assign clr_ovr = accept && last && data_q[STATUS_OVR_BIT];
  assign clr_sat = accept && last && data_q[STATUS_SAT_BIT];

  always_comb begin
    status_now                 = '0;
    status_now[STATUS_OVR_BIT] = ovr_q;
    status_now[STATUS_SAT_BIT] = sat_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (cap_valid) state_d = W_SEND;
      W_SEND:  if (accept && last) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= W_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q    <= '0;
      high_q   <= '0;
      period_q <= '0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      ovr_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      if ((state_q == W_IDLE) && cap_valid) begin
        high_q   <= cap_high;
        period_q <= cap_period;
        idx_q    <= '0;
        addr_q   <= BASE_ADDR;
        data_q   <= cap_high[7:0];
      end else if (accept && !last) begin
        idx_q  <= idx_q + 3'd1;
        addr_q <= BASE_ADDR + 8'(idx_q + 3'd1);
        data_q <= cap_byte(high_q, period_q, status_now, idx_q + 3'd1);
      end
      ovr_q <= (ovr_q && !clr_ovr) || ovr_evt;
      sat_q <= (sat_q && !clr_sat) || sat_evt;
    end
  end

  assign reg_wr_valid = (state_q == W_SEND);
  assign cap_busy     = (state_q != W_IDLE);
  assign reg_wr_addr  = addr_q;
  assign reg_wr_data  = data_q;

endmodule

// File: rtl/pwm_capture.sv
// Input capture: measures high time and period of pwm_in on a prescaled
// time base and writes the results to the register file.
// Optional: PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample majority filter.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h0C
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm_in,
  input  logic [7:0] cap_div,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic       reg_wr_ready,
  output logic       cap_busy
);

  logic        s1_q, s2_q, level, level_q, rise;
  logic [7:0]  div_q;
  logic        tick, enabled;
  logic [15:0] high_q, period_q;
  logic        cap_valid, sat_evt;
  meas_state_t state_q, state_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic f1_q, f2_q, filt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      f1_q   <= s2_q;
      f2_q   <= f1_q;
      filt_q <= (s2_q & f1_q) | (s2_q & f2_q) | (f1_q & f2_q);
    end
  end

  assign level = filt_q;
`else
  assign level = s2_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise    = level & ~level_q;
  assign enabled = (cap_div != '0);
  assign tick    = (div_q >= cap_div);

  // Prescaler: the rise cycle counts as the first clock of a tick interval.
  always_ff @(posedge clock) begin
    if (!reset)          div_q <= '0;
    else if (rise||tick) div_q <= 8'd1;
    else                 div_q <= div_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    cap_valid = 1'b0;
    if (!enabled) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = MEASURE;
        MEASURE: if (rise) cap_valid = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign sat_evt = enabled && (state_q == MEASURE) && !rise && tick &&
                   ((period_q == '1) || (level && (high_q == '1)));

  always_ff @(posedge clock) begin
    if (!reset || !enabled) begin
      high_q   <= '0;
      period_q <= '0;
    end else if (rise) begin
      high_q   <= 16'd1;
      period_q <= 16'd1;
    end else if (state_q == IDLE) begin
      high_q   <= '0;
      period_q <= '0;
    end else if (tick) begin
      if (period_q != '1)           period_q <= period_q + 16'd1;
      if (level && (high_q != '1))  high_q   <= high_q + 16'd1;
    end
  end

  pwm_capture_writer #(.BASE_ADDR(BASE_ADDR)) u_writer (
    .clock        (clock),
    .reset        (reset),
    .cap_valid    (cap_valid),
    .cap_high     (high_q),
    .cap_period   (period_q),
    .sat_evt      (sat_evt),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ready (reg_wr_ready),
    .cap_busy     (cap_busy)
  );

endmodule
